// File: rtl/mc_exec_wb.sv
// mc_exec_wb: execute/writeback sequencer for the multicycle processor.
// Takes one decoded instruction at a time, reads its two operands from the
// register file, runs the ALU, optionally does one data-memory access, and
// issues one write-back cycle.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   instr_valid/ready   instruction handshake (ready only while idle)
//   instr[31:0]         opcode/rs/rt/rd/funct/imm encoding
//   rf_rs, rf_rt        register-file read selects; rf_a, rf_b returned operands
//   rf_rd/wdata/we      write-back port (one-cycle strobe)
//   mem_req/we/addr/wdata, mem_rdata, mem_ack   data-memory request/response
//   done, illegal, br_taken, br_offset          retirement status pulses
module mc_exec_wb (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [4:0]  rf_rs,
    output logic [4:0]  rf_rt,
    input  logic [31:0] rf_a,
    input  logic [31:0] rf_b,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic        rf_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        done,
    output logic        illegal,
    output logic        br_taken,
    output logic [31:0] br_offset
);
    typedef enum logic [2:0] {IDLE, READ, EXEC, MEM, WB} state_t;

    state_t      r_state;
    logic [31:0] r_ir, r_a, r_b, r_result;

    // Field decode from the latched instruction
    logic [5:0]  w_op, w_fn;
    logic [15:0] w_imm;
    logic [31:0] w_sx, w_alu;
    logic        w_is_r, w_r_ok, w_addi, w_andi, w_lw, w_sw, w_beq;
    logic        w_alu_op, w_illegal;

    assign w_op   = r_ir[31:26];
    assign w_fn   = r_ir[5:0];
    assign w_imm  = r_ir[15:0];
    assign w_sx   = {{16{w_imm[15]}}, w_imm};
    assign w_is_r = (w_op == 6'h00);
    assign w_addi = (w_op == 6'h08);
    assign w_andi = (w_op == 6'h0C);
    assign w_lw   = (w_op == 6'h23);
    assign w_sw   = (w_op == 6'h2B);
    assign w_beq  = (w_op == 6'h04);
    assign w_r_ok = (w_fn == 6'h20) || (w_fn == 6'h22) || (w_fn == 6'h24) ||
                    (w_fn == 6'h25) || (w_fn == 6'h2A);
    assign w_alu_op  = (w_is_r && w_r_ok) || w_addi || w_andi;
    assign w_illegal = !(w_alu_op || w_lw || w_sw || w_beq);

    always_comb begin
        w_alu = 32'h0;
        if (w_is_r) begin
            case (w_fn)
                6'h20:   w_alu = r_a + r_b;
                6'h22:   w_alu = r_a - r_b;
                6'h24:   w_alu = r_a & r_b;
                6'h25:   w_alu = r_a | r_b;
                6'h2A:   w_alu = {31'h0, $signed(r_a) < $signed(r_b)};
                default: w_alu = 32'h0;
            endcase
        end else if (w_addi) begin
            w_alu = r_a + w_sx;
        end else if (w_andi) begin
            w_alu = r_a & {16'h0, w_imm};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ir     <= 32'h0;
            r_a      <= 32'h0;
            r_b      <= 32'h0;
            r_result <= 32'h0;
        end else begin
            case (r_state)
                IDLE: if (instr_valid) begin
                    r_ir    <= instr;
                    r_state <= READ;
                end
                READ: begin
                    r_a     <= rf_a;
                    r_b     <= rf_b;
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_result <= w_alu;
                    if (w_alu_op)          r_state <= WB;
                    else if (w_lw || w_sw) r_state <= MEM;
                    else                   r_state <= IDLE;
                end
                MEM: if (mem_ack) begin
                    if (w_lw) begin
                        r_result <= mem_rdata;
                        r_state  <= WB;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                WB:      r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read selects come straight from IR, so they stay put until the next accept
    assign instr_ready = (r_state == IDLE) && !rst;
    assign rf_rs       = r_ir[25:21];
    assign rf_rt       = r_ir[20:16];
    assign rf_rd       = w_is_r ? r_ir[15:11] : r_ir[20:16];
    assign rf_wdata    = r_result;
    assign rf_we       = !rst && (r_state == WB) && (rf_rd != 5'd0);

    assign mem_req     = (r_state == MEM);
    assign mem_we      = (r_state == MEM) && w_sw;
    assign mem_addr    = r_a + w_sx;
    assign mem_wdata   = r_b;

    // sw retires in the ack cycle itself; beq/illegal retire at the end of EXEC
    assign done     = !rst && ((r_state == WB) ||
                               ((r_state == EXEC) && (w_beq || w_illegal)) ||
                               ((r_state == MEM) && mem_ack && w_sw));
    assign illegal  = !rst && (r_state == EXEC) && w_illegal;
    assign br_taken = !rst && (r_state == EXEC) && w_beq && (r_a == r_b);
    assign br_offset = {w_sx[29:0], 2'b00};
endmodule

// File: tb/tb_mc_exec_wb.sv
module tb_mc_exec_wb;
    logic        clk = 0, rst = 1, instr_valid = 0;
    logic        instr_ready;
    logic [31:0] instr = 0;
    logic [4:0]  rf_rs, rf_rt, rf_rd;
    logic [31:0] rf_a, rf_b, rf_wdata;
    logic        rf_we, mem_req, mem_we, done, illegal, br_taken;
    logic [31:0] mem_addr, mem_wdata, br_offset;
    logic [31:0] mem_rdata = 32'hDEADBEEF;
    logic        mem_ack = 0;

    mc_exec_wb dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_a(rf_a), .rf_b(rf_b),
        .rf_rd(rf_rd), .rf_wdata(rf_wdata), .rf_we(rf_we), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .done(done), .illegal(illegal),
        .br_taken(br_taken), .br_offset(br_offset));

    always #5 clk = ~clk;

    logic [31:0] regs [0:31];
    assign rf_a = regs[rf_rs];
    assign rf_b = regs[rf_rt];

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        ill;
        logic        br;
        logic [31:0] off;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    int nchk = 0, nerr = 0, cyc = 0, last_done = -10;
    int ack_dly = 1, mem_cnt = 0, mem_total = 0;
    logic mem_exp = 0, exp_mwe = 0;
    logic [31:0] exp_addr = 0, exp_mwd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory responder: acks on the ack_dly-th request cycle, checks request stability
    always @(negedge clk) begin
        if (mem_req) begin
            mem_cnt++;
            mem_total++;
            if (!mem_exp) chk("mem_unexp", {31'h0, mem_req}, 32'h0);
            else begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_we", {31'h0, mem_we}, {31'h0, exp_mwe});
                if (exp_mwe) chk("mem_wdata", mem_wdata, exp_mwd);
            end
            mem_ack = (mem_cnt == ack_dly);
        end else begin
            mem_cnt = 0;
            mem_ack = 0;
        end
    end

    // Retirement monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        #2;
        if (rf_we && !done) chk("we_wo_done", {31'h0, rf_we}, 32'h0);
        if (done) begin
            if (sb.size() == 0) chk("done_unexp", {31'h0, done}, 32'h0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("rf_we", {31'h0, rf_we}, {31'h0, e.we});
                if (e.we) begin
                    chk("rf_rd", {27'h0, rf_rd}, {27'h0, e.rd});
                    chk("rf_wdata", rf_wdata, e.wd);
                end
                chk("illegal", {31'h0, illegal}, {31'h0, e.ill});
                chk("br_taken", {31'h0, br_taken}, {31'h0, e.br});
                if (e.br) chk("br_offset", br_offset, e.off);
                chk("latency", cyc - e.acc, e.lat);
            end
            last_done = cyc;
        end
    end

    function automatic logic [31:0] rtype(input int rs, rt, rd, input logic [5:0] fn);
        rtype = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h0, fn};
    endfunction
    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, rt, input logic [15:0] imm);
        itype = {op, 5'(rs), 5'(rt), imm};
    endfunction

    // Reference model: builds the expected retirement record for one instruction
    task automatic send(input logic [31:0] ins, input bit b2b);
        exp_t e;
        logic [5:0] op, fn;
        logic [31:0] a, b, sx;
        logic wb;
        logic [4:0] dst;
        op = ins[31:26]; fn = ins[5:0];
        a = regs[ins[25:21]]; b = regs[ins[20:16]];
        sx = {{16{ins[15]}}, ins[15:0]};
        e.we = 0; e.rd = 0; e.wd = 0; e.ill = 0; e.br = 0; e.off = 0; e.lat = 3;
        wb = 1; dst = ins[20:16];
        case (op)
            6'h00: begin
                dst = ins[15:11];
                case (fn)
                    6'h20: e.wd = a + b;
                    6'h22: e.wd = a - b;
                    6'h24: e.wd = a & b;
                    6'h25: e.wd = a | b;
                    6'h2A: e.wd = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: begin e.ill = 1; wb = 0; e.lat = 2; end
                endcase
            end
            6'h08: e.wd = a + sx;
            6'h0C: e.wd = a & {16'h0, ins[15:0]};
            6'h23: begin e.wd = mem_rdata; e.lat = 3 + ack_dly;
                   mem_exp = 1; exp_addr = a + sx; exp_mwe = 0; end
            6'h2B: begin wb = 0; e.lat = 2 + ack_dly;
                   mem_exp = 1; exp_addr = a + sx; exp_mwe = 1; exp_mwd = b; end
            6'h04: begin wb = 0; e.lat = 2; e.br = (a == b); e.off = sx << 2; end
            default: begin e.ill = 1; wb = 0; e.lat = 2; end
        endcase
        e.we = wb && (dst != 0);
        e.rd = dst;
        @(negedge clk);
        for (int i = 0; i < 100 && !instr_ready; i++) @(negedge clk);
        if (!instr_ready) chk("ready_timeout", 0, 1);
        if (b2b) chk("b2b_accept", cyc, last_done + 1);
        instr_valid = 1; instr = ins;
        e.acc = cyc;
        sb.push_back(e);
        @(negedge clk);
        instr_valid = 0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
        mem_exp = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[1] = 5; regs[2] = 7; regs[4] = 0; regs[5] = 1;
        regs[7] = 32'hFFFFFFFF; regs[8] = 32'h100;

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, instr_ready}, 0);
        chk("rst_done", {31'h0, done}, 0);
        chk("rst_we", {31'h0, rf_we}, 0);
        chk("rst_mreq", {31'h0, mem_req}, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_maddr", mem_addr, 0);
        rst = 0;
        @(negedge clk);
        chk("ready_after_rst", {31'h0, instr_ready}, 1);

        send(rtype(1, 2, 3, 6'h20), 0); wait_done();   // add 5+7
        send(rtype(4, 5, 6, 6'h22), 0); wait_done();   // sub 0-1
        send(rtype(7, 5, 10, 6'h2A), 0); wait_done();  // slt -1<1
        send(rtype(1, 2, 11, 6'h24), 0); wait_done();  // and
        send(rtype(1, 2, 12, 6'h25), 0); wait_done();  // or
        send(itype(6'h08, 1, 0, 16'h0003), 0); wait_done(); // addi to r0
        send(itype(6'h08, 1, 13, 16'hFFFE), 0); wait_done(); // addi negative
        send(itype(6'h0C, 7, 14, 16'h8001), 0); wait_done(); // andi zero-ext

        ack_dly = 3; mem_total = 0;
        send(itype(6'h23, 8, 9, 16'hFFFC), 0); wait_done(); // lw, slow ack
        chk("lw_req_cycles", mem_total, 3);

        ack_dly = 1; mem_total = 0;
        send(itype(6'h2B, 8, 2, 16'h0004), 0); wait_done(); // sw, fast ack
        chk("sw_req_cycles", mem_total, 1);

        send(itype(6'h04, 1, 1, 16'hFFFF), 0); wait_done(); // beq taken
        send(itype(6'h04, 1, 2, 16'h0010), 0); wait_done(); // beq not taken
        mem_total = 0;
        send(itype(6'h3F, 1, 2, 16'h1234), 0); wait_done(); // illegal opcode
        send(rtype(1, 2, 3, 6'h3F), 0); wait_done();        // illegal funct
        chk("ill_no_mem", mem_total, 0);

        // Reset during MEM abandons the store
        ack_dly = 1000;
        send(itype(6'h2B, 8, 2, 16'h0008), 0);
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        chk("mreq_before_rst", {31'h0, mem_req}, 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("rst_mid_mreq", {31'h0, mem_req}, 0);
        chk("rst_mid_done", {31'h0, done}, 0);
        chk("rst_mid_we", {31'h0, rf_we}, 0);
        chk("rst_mid_ready", {31'h0, instr_ready}, 0);
        sb.delete();
        mem_exp = 0; ack_dly = 1;
        rst = 0;
        @(negedge clk);
        chk("ready_post_rst", {31'h0, instr_ready}, 1);

        // Back-to-back stream
        send(rtype(1, 2, 3, 6'h20), 0);
        send(itype(6'h08, 2, 15, 16'h0010), 1);
        send(itype(6'h04, 2, 2, 16'h0001), 1);
        send(rtype(7, 1, 16, 6'h22), 1);
        wait_done();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
